// File: rtl/wfifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port round-robin arbiter.
package wfifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;

  // $clog2 floored at 1 so a degenerate parameter never yields a zero-width vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wfifo_rr_arbiter_if.sv
// Requester bundle plus FIFO write port seen by the arbiter.
interface wfifo_rr_arbiter_if
  import wfifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         wdata;

  // The arbiter masters the FIFO write port and answers the requesters.
  modport master (
    input  req_valid, req_data, req_last, full,
    output req_ready, w_en, wdata
  );

  modport slave (
    output req_valid, req_data, req_last, full,
    input  req_ready, w_en, wdata
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam int PW = $clog2(2 * N);

  logic [2*N-1:0] dbl;
  logic [PW-1:0]  pos;
  logic [IW:0]    sum;

  // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    dbl   = {req, req};
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    // Descending scan leaves the lowest offset from start as the winner.
    for (int i = N - 1; i >= 0; i--) begin
      pos = PW'(start) + PW'(i);
      if (dbl[pos]) begin
        found = 1'b1;
        sum   = (IW+1)'(start) + (IW+1)'(i);
      end
    end
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/wfifo_rr_arbiter.sv
// Round-robin, burst-holding arbiter sharing one async-FIFO write port (wclk domain).
module wfifo_rr_arbiter
  import wfifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic                           wclk,
  input  logic                           wrst,
  wfifo_rr_arbiter_if.master             bus,
  output logic [clog2_min1(NUM_REQ)-1:0] grant_id,
  output logic                           busy
);

  localparam int ID_W   = clog2_min1(NUM_REQ);
  localparam int BEAT_W = clog2_min1(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  arb_state_t            state;
  logic [ID_W-1:0]       ptr;
  logic [BEAT_W-1:0]     beat;
  logic                  found;
  logic [ID_W-1:0]       pick;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_picker #(.N(NUM_REQ), .IW(ID_W)) u_picker (
    .req   (bus.req_valid),
    .start (ptr),
    .found (found),
    .idx   (pick)
  );

  // Constant-index mux keeps other requesters' data off the write bus.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_id) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.w_en      = 1'b0;
    bus.wdata     = '0;
    if (state == ARB_GRANT) begin
      for (int i = 0; i < NUM_REQ; i++)
        bus.req_ready[i] = (ID_W'(i) == grant_id) && !bus.full;
      bus.w_en  = sel_valid && !bus.full;
      bus.wdata = sel_data;
    end
  end

  // NOTE: state uses non-blocking assignments and an async active-low reset in the sensitivity list.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state    <= ARB_IDLE;
      grant_id <= '0;
      ptr      <= '0;
      beat     <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            grant_id <= pick;
            beat     <= '0;
            busy     <= 1'b1;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (bus.w_en) begin
            if (sel_last || beat == LAST_BEAT) begin
              ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
              beat  <= '0;
              busy  <= 1'b0;
              state <= ARB_IDLE;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfifo_rr_arbiter.sv
// Directed, table-driven bench for wfifo_rr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_wfifo_rr_arbiter;

  logic       wclk;
  logic       wrst;
  logic [1:0] grant_id;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  wfifo_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  wfifo_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic        exp_wen;
    logic [7:0]  exp_wdata;
    logic [1:0]  exp_gid;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[18];

  // Owner lane carries b; every other lane carries a distinct decoy byte.
  function automatic logic [31:0] lane(input int i, input logic [7:0] b);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = (j == i) ? b : 8'(8'hD0 + j);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic [3:0] rdy, input logic wen,
                            input logic [7:0] wd, input logic [1:0] gid, input logic bsy);
    check({tag, ".req_ready"}, 32'(bus.req_ready), 32'(rdy));
    check({tag, ".w_en"},      32'(bus.w_en),      32'(wen));
    check({tag, ".wdata"},     32'(bus.wdata),     32'(wd));
    check({tag, ".grant_id"},  32'(grant_id),      32'(gid));
    check({tag, ".busy"},      32'(busy),          32'(bsy));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [31:0] d);
    @(negedge wclk);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.full      = f;
    bus.req_data  = d;
    #1;
  endtask

  initial begin
    int g;
    int prev;
    wrst          = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.full      = 1'b0;
    bus.req_data  = '0;

    vecs[0]  = '{4'b0010, 4'b0000, 1'b0, lane(1, 8'h11), 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{4'b0010, 4'b0000, 1'b0, lane(1, 8'h11), 4'b0010, 1'b1, 8'h11, 2'd1, 1'b1};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, lane(1, 8'h12), 4'b0010, 1'b0, 8'h12, 2'd1, 1'b1};
    vecs[3]  = '{4'b0010, 4'b0000, 1'b0, lane(1, 8'h12), 4'b0010, 1'b1, 8'h12, 2'd1, 1'b1};
    vecs[4]  = '{4'b0010, 4'b0010, 1'b0, lane(1, 8'h13), 4'b0010, 1'b1, 8'h13, 2'd1, 1'b1};
    vecs[5]  = '{4'b0000, 4'b0000, 1'b0, lane(1, 8'h00), 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    vecs[6]  = '{4'b0100, 4'b0000, 1'b0, lane(2, 8'h21), 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    vecs[7]  = '{4'b0100, 4'b0000, 1'b0, lane(2, 8'h21), 4'b0100, 1'b1, 8'h21, 2'd2, 1'b1};
    vecs[8]  = '{4'b0100, 4'b0000, 1'b1, lane(2, 8'h22), 4'b0000, 1'b0, 8'h22, 2'd2, 1'b1};
    vecs[9]  = '{4'b0100, 4'b0000, 1'b1, lane(2, 8'h22), 4'b0000, 1'b0, 8'h22, 2'd2, 1'b1};
    vecs[10] = '{4'b0100, 4'b0000, 1'b0, lane(2, 8'h22), 4'b0100, 1'b1, 8'h22, 2'd2, 1'b1};
    vecs[11] = '{4'b0100, 4'b0000, 1'b0, lane(2, 8'h23), 4'b0100, 1'b1, 8'h23, 2'd2, 1'b1};
    vecs[12] = '{4'b0100, 4'b0000, 1'b0, lane(2, 8'h24), 4'b0100, 1'b1, 8'h24, 2'd2, 1'b1};
    vecs[13] = '{4'b0101, 4'b0000, 1'b0, 32'hD325_D101,  4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};
    vecs[14] = '{4'b0101, 4'b0001, 1'b0, 32'hD325_D101,  4'b0001, 1'b1, 8'h01, 2'd0, 1'b1};
    vecs[15] = '{4'b0100, 4'b0000, 1'b0, 32'hD325_D1D0,  4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[16] = '{4'b0100, 4'b0100, 1'b0, 32'hD325_D1D0,  4'b0100, 1'b1, 8'h25, 2'd2, 1'b1};
    vecs[17] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000,  4'b0000, 1'b0, 8'h00, 2'd2, 1'b0};

    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    check_outs("reset", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge wclk);
    wrst = 1'b1;

    for (int k = 0; k < 18; k++) begin
      drive(vecs[k].valid, vecs[k].last, vecs[k].full, vecs[k].data);
      check_outs($sformatf("vec%0d", k), vecs[k].exp_ready, vecs[k].exp_wen,
                 vecs[k].exp_wdata, vecs[k].exp_gid, vecs[k].exp_busy);
    end

    // Mid-burst reset: req1 owns the port and has written two beats.
    drive(4'b0010, 4'b0000, 1'b0, lane(1, 8'h31));
    check_outs("mid_arb", 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);
    drive(4'b0010, 4'b0000, 1'b0, lane(1, 8'h31));
    check_outs("mid_b0", 4'b0010, 1'b1, 8'h31, 2'd1, 1'b1);
    drive(4'b0010, 4'b0000, 1'b0, lane(1, 8'h32));
    check_outs("mid_b1", 4'b0010, 1'b1, 8'h32, 2'd1, 1'b1);
    @(negedge wclk);
    wrst = 1'b0;
    #1;
    check_outs("rst_async", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    check_outs("rst_hold", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    #1;
    wrst = 1'b1;

    // All four requesters valid with no last: MAX_BURST bursts in strict rotation.
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      drive(4'b1111, 4'b0000, 1'b0, 32'hA3A2_A1A0);
      check_outs($sformatf("rr%0d_idle", n), 4'b0000, 1'b0, 8'h00, 2'(prev), 1'b0);
      for (int b = 0; b < 4; b++) begin
        drive(4'b1111, 4'b0000, 1'b0, 32'hA3A2_A1A0);
        check_outs($sformatf("rr%0d_b%0d", n, b), 4'(1 << g), 1'b1, 8'(8'hA0 + g), 2'(g), 1'b1);
      end
      prev = g;
    end

    drive(4'b0000, 4'b0000, 1'b0, 32'h0);
    check_outs("end_idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
